mult_share_arb: RTL and testbench
=================================

Name: mult_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one pipelined unsigned WIDTHxWIDTH multiplier between N_REQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- The block grants at most one requester per cycle, pushes the pair and a requester tag down the multiplier pipeline, and returns the product to the owner as a one-cycle response pulse.
- Sits between LED/demo counter logic (or any operand producers) and the DSP multiplier resource.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 4, operand width in bits; product is 2*WIDTH
- PIPE, 2, product register stages after operand capture (1..4)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  high: grants allowed; low: no new grants, pipeline keeps draining
- req_valid  in  N_REQ  per-requester operand pair valid
- req_a  in  N_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- req_b  in  N_REQ*WIDTH  operand B, same packing
- req_ready  out  N_REQ  one-hot (or zero) grant; transfer when req_valid[i] & req_ready[i]
- rsp_valid  out  N_REQ  one-hot, one-cycle pulse to the owning requester
- rsp_data  out  2*WIDTH  product, meaningful only while any rsp_valid bit is high
- busy  out  1  high while any pipeline stage holds a valid operation

Behaviour:
- Reset (async assert, sync to clk on release):
  - rsp_valid=0, rsp_data=0, busy=0.
  - All pipeline valid bits cleared; in-flight operations discarded, no response ever issued for them.
  - RR pointer=N_REQ-1, so requester 0 has highest priority after reset.
- req_ready:
  - Combinational from req_valid, en and the RR pointer. Ready may depend on valid (arbiter convention); requesters must not make valid depend on ready.
  - All zero while rst or en=0.
- Arbitration:
  - Scan starts at pointer+1 mod N_REQ and wraps; the first i with req_valid[i]=1 gets req_ready[i]=1.
  - On a transfer, the pointer updates to i at that edge. With no transfer, the pointer holds.
  - A requester holding valid continuously is granted at most once every N_REQ cycles when all others also request.
  - A sole requester is granted every cycle (full throughput, 1 op/cycle).
- Pipeline:
  - At the accepting edge k, capture a, b, tag=i and valid=1 into stage 0.
  - Unsigned product is 2*WIDTH bits with no truncation or overflow.
  - Product passes PIPE registers.
  - rsp_valid[tag] and rsp_data are visible after edge k+PIPE, for exactly one cycle.
  - Stages always advance (no response backpressure). Requesters must accept the response when it is presented.
- Ordering: responses emerge in grant order; back-to-back grants yield back-to-back pulses.
- busy: OR of all stage valid bits including the output register. It falls in the cycle after the last rsp_valid pulse.
- en deasserted mid-stream: operations already accepted complete normally; new grants resume on the first cycle en=1, using the held pointer.
- Reset asserted while busy=1: outputs clear immediately (asynchronous); nothing is emitted after reset releases.
- rsp_data while no rsp_valid: holds its last value (not required to be zero except after reset).

Optional Feature:
- Macro MULT_SHARE_ARB_STATS_EN.
- Defined:
  - Adds output port grant_cnt, N_REQ*16 bits.
  - Per-requester 16-bit saturating count of accepted transfers, cleared by rst.
  - Saturates at 16'hFFFF (no wrap).
  - Increments on the transfer edge.
- Undefined:
  - Port and counters absent.
  - All other behaviour is identical cycle for cycle.

Test Plan:
- Reset then single op, req0 a=4'hF b=4'hF en=1, PIPE=2: req_ready=4'b0001 same cycle; rsp_valid=4'b0001, rsp_data=8'hE1 two edges later; busy 1 for 3 cycles.
- All four requesters valid continuously for 8 cycles, a=i+1, b=3: grant order 0,1,2,3,0,1,2,3. Responses in the same order with data 3,6,9,12 repeating.
- Req2 alone valid for 5 cycles with a=cycle index 0..4, b=4'h7: 5 consecutive grants. Five back-to-back pulses rsp_data=0,7,14,21,28.
- en=0 with req1 valid for 3 cycles, then en=1: req_ready=0 for those 3 cycles; grant on the first en=1 cycle; response PIPE edges later.
- Two ops accepted, then rst pulsed one cycle before the first response is due: no rsp_valid ever pulses; busy=0 immediately; the next request grants req0 first.
- With MULT_SHARE_ARB_STATS_EN defined:
  - Req3 valid for 70000 cycles: grant_cnt[63:48] stops at 16'hFFFF; other counts stay 0.
  - Without the macro, the same stimulus produces an identical rsp trace.

Source files
------------

// File: rtl/mult_share_arb.sv
// Round-robin share of one pipelined WIDTHxWIDTH unsigned multiplier among N_REQ requesters.
// Optional per-requester grant counters when MULT_SHARE_ARB_STATS_EN is defined.
module mult_share_arb #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4,
  parameter int PIPE  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [2*WIDTH-1:0]       rsp_data,
`ifdef MULT_SHARE_ARB_STATS_EN
  output logic [N_REQ*16-1:0]      grant_cnt,
`endif
  output logic                     busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW = 2 * WIDTH;

  logic [IW-1:0]    ptr;
  logic [IW-1:0]    gidx;
  logic [N_REQ-1:0] grant;
  logic             acc;

  logic             s0_vld;
  logic [WIDTH-1:0] s0_a;
  logic [WIDTH-1:0] s0_b;
  logic [IW-1:0]    s0_tag;

  logic [PW-1:0]    p_dat [PIPE];
  logic [IW-1:0]    p_tag [PIPE];
  logic [PIPE-1:0]  p_vld;

  // Scan starts just after the last winner and wraps, so the last winner is lowest priority.
  always_comb begin
    int  idx;
    logic found;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = (int'(ptr) + off) % N_REQ;
      if (!found && req_valid[idx]) begin
        grant[idx] = 1'b1;
        gidx       = IW'(idx);
        found      = 1'b1;
      end
    end
  end

  assign req_ready = (en && !rst) ? grant : '0;
  assign acc       = |(req_ready & req_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= IW'(N_REQ - 1);
      s0_vld <= 1'b0;
      s0_a   <= '0;
      s0_b   <= '0;
      s0_tag <= '0;
      p_vld  <= '0;
      for (int j = 0; j < PIPE; j++) begin
        p_dat[j] <= '0;
        p_tag[j] <= '0;
      end
    end else begin
      s0_vld <= acc;
      if (acc) begin
        s0_a   <= req_a[gidx*WIDTH +: WIDTH];
        s0_b   <= req_b[gidx*WIDTH +: WIDTH];
        s0_tag <= gidx;
        ptr    <= gidx;
      end
      p_vld[0] <= s0_vld;
      if (s0_vld) begin
        p_dat[0] <= PW'(s0_a) * PW'(s0_b);
        p_tag[0] <= s0_tag;
      end
      // Data only moves with a valid op so the output holds its last product when idle.
      for (int j = 1; j < PIPE; j++) begin
        p_vld[j] <= p_vld[j-1];
        if (p_vld[j-1]) begin
          p_dat[j] <= p_dat[j-1];
          p_tag[j] <= p_tag[j-1];
        end
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (p_vld[PIPE-1]) rsp_valid[p_tag[PIPE-1]] = 1'b1;
  end

  assign rsp_data = p_dat[PIPE-1];
  assign busy     = s0_vld | (|p_vld);

`ifdef MULT_SHARE_ARB_STATS_EN
  logic [15:0] cnt [N_REQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_ready[i] && req_valid[i] && cnt[i] != 16'hFFFF) cnt[i] <= cnt[i] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
    assign grant_cnt[g*16 +: 16] = cnt[g];
  end
`endif

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb (N_REQ=4, WIDTH=4, PIPE=2): per-cycle vector table plus corner sequences.
module tb_mult_share_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        busy;
`ifdef MULT_SHARE_ARB_STATS_EN
  logic [63:0] grant_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_share_arb #(.N_REQ(4), .WIDTH(4), .PIPE(2)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
`ifdef MULT_SHARE_ARB_STATS_EN
    .grant_cnt(grant_cnt),
`endif
    .busy(busy)
  );

  typedef struct packed {
    logic        r;
    logic        e;
    logic [3:0]  v;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  rdy;
    logic [3:0]  rv;
    logic [7:0]  rd;
    logic        bsy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic e, input logic [3:0] v, input logic [15:0] a,
                     input logic [15:0] b, input logic [3:0] rdy, input logic [3:0] rv,
                     input logic [7:0] rd, input logic bsy);
    vec_t t;
    t.r = r; t.e = e; t.v = v; t.a = a; t.b = b;
    t.rdy = rdy; t.rv = rv; t.rd = rd; t.bsy = bsy;
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    // Reset, then one F*F op from req0.
    add(1,0,4'b0000,16'h0000,16'h0000, 4'b0000,4'b0000,8'h00,0);
    add(0,1,4'b0001,16'h000F,16'h000F, 4'b0001,4'b0000,8'h00,0);
    add(0,1,4'b0000,16'h0000,16'h0000, 4'b0000,4'b0000,8'h00,1);
    add(0,1,4'b0000,16'h0000,16'h0000, 4'b0000,4'b0000,8'h00,1);
    add(0,1,4'b0000,16'h0000,16'h0000, 4'b0000,4'b0001,8'hE1,1);
    add(0,1,4'b0000,16'h0000,16'h0000, 4'b0000,4'b0000,8'h00,0);
    // Reset, then all four requesting for 8 cycles, a=i+1, b=3.
    add(1,1,4'b1111,16'h4321,16'h3333, 4'b0000,4'b0000,8'h00,0);
    add(0,1,4'b1111,16'h4321,16'h3333, 4'b0001,4'b0000,8'h00,0);
    add(0,1,4'b1111,16'h4321,16'h3333, 4'b0010,4'b0000,8'h00,1);
    add(0,1,4'b1111,16'h4321,16'h3333, 4'b0100,4'b0000,8'h00,1);
    add(0,1,4'b1111,16'h4321,16'h3333, 4'b1000,4'b0001,8'h03,1);
    add(0,1,4'b1111,16'h4321,16'h3333, 4'b0001,4'b0010,8'h06,1);
    add(0,1,4'b1111,16'h4321,16'h3333, 4'b0010,4'b0100,8'h09,1);
    add(0,1,4'b1111,16'h4321,16'h3333, 4'b0100,4'b1000,8'h0C,1);
    add(0,1,4'b1111,16'h4321,16'h3333, 4'b1000,4'b0001,8'h03,1);
    add(0,1,4'b0000,16'h0000,16'h0000, 4'b0000,4'b0010,8'h06,1);
    add(0,1,4'b0000,16'h0000,16'h0000, 4'b0000,4'b0100,8'h09,1);
    add(0,1,4'b0000,16'h0000,16'h0000, 4'b0000,4'b1000,8'h0C,1);
    add(0,1,4'b0000,16'h0000,16'h0000, 4'b0000,4'b0000,8'h00,0);
    // Req2 alone for 5 cycles, a=0..4, b=7.
    add(0,1,4'b0100,16'h0000,16'h0700, 4'b0100,4'b0000,8'h00,0);
    add(0,1,4'b0100,16'h0100,16'h0700, 4'b0100,4'b0000,8'h00,1);
    add(0,1,4'b0100,16'h0200,16'h0700, 4'b0100,4'b0000,8'h00,1);
    add(0,1,4'b0100,16'h0300,16'h0700, 4'b0100,4'b0100,8'h00,1);
    add(0,1,4'b0100,16'h0400,16'h0700, 4'b0100,4'b0100,8'h07,1);
    add(0,1,4'b0000,16'h0000,16'h0000, 4'b0000,4'b0100,8'h0E,1);
    add(0,1,4'b0000,16'h0000,16'h0000, 4'b0000,4'b0100,8'h15,1);
    add(0,1,4'b0000,16'h0000,16'h0000, 4'b0000,4'b0100,8'h1C,1);
    add(0,1,4'b0000,16'h0000,16'h0000, 4'b0000,4'b0000,8'h00,0);
    // en low with req1 waiting, then en high: 5*6.
    add(0,0,4'b0010,16'h0050,16'h0060, 4'b0000,4'b0000,8'h00,0);
    add(0,0,4'b0010,16'h0050,16'h0060, 4'b0000,4'b0000,8'h00,0);
    add(0,0,4'b0010,16'h0050,16'h0060, 4'b0000,4'b0000,8'h00,0);
    add(0,1,4'b0010,16'h0050,16'h0060, 4'b0010,4'b0000,8'h00,0);
    add(0,1,4'b0000,16'h0000,16'h0000, 4'b0000,4'b0000,8'h00,1);
    add(0,1,4'b0000,16'h0000,16'h0000, 4'b0000,4'b0000,8'h00,1);
    add(0,1,4'b0000,16'h0000,16'h0000, 4'b0000,4'b0010,8'h1E,1);
    add(0,1,4'b0000,16'h0000,16'h0000, 4'b0000,4'b0000,8'h00,0);
    // Two ops in flight, reset one cycle before the first response; then req0 wins first.
    add(0,1,4'b0011,16'h0022,16'h0033, 4'b0001,4'b0000,8'h00,0);
    add(0,1,4'b0011,16'h0022,16'h0033, 4'b0010,4'b0000,8'h00,1);
    add(1,1,4'b0011,16'h0022,16'h0033, 4'b0000,4'b0000,8'h00,0);
    add(0,1,4'b0000,16'h0000,16'h0000, 4'b0000,4'b0000,8'h00,0);
    add(0,1,4'b0000,16'h0000,16'h0000, 4'b0000,4'b0000,8'h00,0);
    add(0,1,4'b1111,16'h0022,16'h0033, 4'b0001,4'b0000,8'h00,0);
    add(0,1,4'b0000,16'h0000,16'h0000, 4'b0000,4'b0000,8'h00,1);
    add(0,1,4'b0000,16'h0000,16'h0000, 4'b0000,4'b0000,8'h00,1);
    add(0,1,4'b0000,16'h0000,16'h0000, 4'b0000,4'b0001,8'h06,1);
    add(0,1,4'b0000,16'h0000,16'h0000, 4'b0000,4'b0000,8'h00,0);
    // Sparse valids: pointer at 0 skips to 3, then wraps to 0.
    add(0,1,4'b1001,16'h5002,16'h5003, 4'b1000,4'b0000,8'h00,0);
    add(0,1,4'b1001,16'h5002,16'h5003, 4'b0001,4'b0000,8'h00,1);
    add(0,1,4'b0000,16'h0000,16'h0000, 4'b0000,4'b0000,8'h00,1);
    add(0,1,4'b0000,16'h0000,16'h0000, 4'b0000,4'b1000,8'h19,1);
    add(0,1,4'b0000,16'h0000,16'h0000, 4'b0000,4'b0001,8'h06,1);
    add(0,1,4'b0000,16'h0000,16'h0000, 4'b0000,4'b0000,8'h00,0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].r; en = tbl[i].e; req_valid = tbl[i].v;
      req_a = tbl[i].a; req_b = tbl[i].b;
      #1;
      chk("req_ready", i, 64'(req_ready), 64'(tbl[i].rdy));
      chk("rsp_valid", i, 64'(rsp_valid), 64'(tbl[i].rv));
      chk("busy", i, 64'(busy), 64'(tbl[i].bsy));
      if (tbl[i].rv != 4'b0000 || tbl[i].r) chk("rsp_data", i, 64'(rsp_data), 64'(tbl[i].rd));
    end

    // Reset asserted between edges clears busy at once; nothing emerges afterwards.
    @(negedge clk);
    req_valid = 4'b0001; req_a = 16'h0003; req_b = 16'h0005;
    @(negedge clk);
    req_valid = 4'b0000;
    #2 rst = 1'b1;
    #1;
    chk("async_busy", 0, 64'(busy), 64'd0);
    chk("async_rdy", 0, 64'(req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_rsp", i, 64'(rsp_valid), 64'd0);
    end

`ifdef MULT_SHARE_ARB_STATS_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; en = 1'b1; req_valid = 4'b1000; req_a = 16'h1000; req_b = 16'h1000;
    repeat (65534) @(negedge clk);
    chk("cnt3_fffe", 0, 64'(grant_cnt[63:48]), 64'h0000_0000_0000_FFFE);
    repeat (70000 - 65534) @(negedge clk);
    req_valid = 4'b0000;
    #1;
    chk("cnt3_sat", 0, 64'(grant_cnt[63:48]), 64'h0000_0000_0000_FFFF);
    chk("cnt_others", 0, 64'(grant_cnt[47:0]), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
